// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle between the immediate-extension pipeline and its producer/consumer.
// The slave modport is the pipeline's view; master is the surrounding datapath's view.
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_ovf
    );

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_ovf
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extender: sign/zero/upper/branch widening of an instruction
// immediate, carried with its tag through a STAGES-deep valid/ready pipeline.
module imm_ext_pipe #(
    parameter int IN_W   = 16,
    parameter int OUT_W  = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    imm_ext_pipe_if.slave  bus
);

    logic [OUT_W-1:0] sextVal;
    logic [OUT_W-1:0] extData;
    logic             extOvf;

    logic [STAGES-1:0] stageLoad;
    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] ovf_q, ovf_d;
    logic [OUT_W-1:0]  data_q [STAGES];
    logic [OUT_W-1:0]  data_d [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  tag_d  [STAGES];

    // Branch overflow flags shifted-out bits that disagree with the immediate's sign.
    always_comb begin
        sextVal = OUT_W'($signed(bus.in_imm));
        extData = sextVal;
        extOvf  = 1'b0;
        unique case (bus.in_mode)
            2'b00: extData = sextVal;
            2'b01: extData = OUT_W'(bus.in_imm);
            2'b10: extData = OUT_W'(bus.in_imm) << (OUT_W - IN_W);
            default: begin
                extData = sextVal << 2;
                extOvf  = (sextVal[OUT_W-1 -: 2] != {2{sextVal[OUT_W-1]}});
            end
        endcase
    end

    // A stage can load when it is empty or everything downstream of it can move.
    always_comb begin : readyChain
        logic downLoad;
        downLoad  = bus.out_ready;
        stageLoad = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            stageLoad[k] = !valid_q[k] || downLoad;
            downLoad     = stageLoad[k];
        end
    end

    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (flush) begin
            valid_d = '0;
        end else begin
            if (stageLoad[0]) begin
                valid_d[0] = bus.in_valid;
                if (bus.in_valid) begin
                    data_d[0] = extData;
                    tag_d[0]  = bus.in_tag;
                    ovf_d[0]  = extOvf;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (stageLoad[k]) begin
                    valid_d[k] = valid_q[k-1];
                    if (valid_q[k-1]) begin
                        data_d[k] = data_q[k-1];
                        tag_d[k]  = tag_q[k-1];
                        ovf_d[k]  = ovf_q[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            ovf_q   <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.in_ready  = stageLoad[0] && !flush;
    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out_data  = data_q[STAGES-1];
    assign bus.out_tag   = tag_q[STAGES-1];
    assign bus.out_ovf   = ovf_q[STAGES-1];

endmodule
